bit_stuffer: RTL and testbench
==============================

Name: bit_stuffer

Overview:
- Serial USB transmit stage directly downstream of the CRC stage.
- Consumes the CRC stage's bit stream (s_out/start_b/endb) and inserts a 0 after every STUFF_LEN consecutive 1s, per USB bit-stuffing rules.
- Stalls the CRC stage with pause for one cycle per inserted bit.
- Feeds the NRZI encoder with a registered bit stream plus framing strobes.

Parameters:
- STUFF_LEN, 6, number of consecutive 1s that triggers insertion of a stuff 0.

Ports:
- clk  input  1  system clock, all state on posedge.
- rst_n  input  1  asynchronous active-low reset.
- s_in  input  1  serial bit from the CRC stage; valid each cycle from start_in through end_in inclusive.
- start_in  input  1  pulses with the first bit of a packet.
- end_in  input  1  pulses with the last bit of a packet (last CRC bit).
- pause  output  1  to the CRC stage; when 1, upstream holds s_in/end_in and re-presents them next cycle.
- s_out  output  1  stuffed serial bit, registered.
- start_out  output  1  registered; high with the first output bit.
- end_out  output  1  registered; high with the final output bit, including a trailing stuff bit.
- active_out  output  1  registered; high for every cycle s_out carries a packet bit.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, ones_cnt=0; s_out=0, start_out=0, end_out=0, active_out=0, pause=0. Reset mid-packet aborts the packet immediately. No end_out is produced.
- ones_cnt width: $clog2(STUFF_LEN+1). It counts consecutive 1s emitted, stuff bits excluded.
- Output latency: 1 cycle from a consumed input bit to s_out.
- pause is combinational from registered state only: pause = (state==SEND && ones_cnt==STUFF_LEN). It has no combinational path from inputs.
- States:
  - IDLE: active_out=0 next cycle.
    - On start_in=1: consume s_in, s_out<=s_in, start_out<=1, active_out<=1.
    - ones_cnt<=(s_in ? 1 : 0).
    - If end_in is also 1 (1-bit packet): go to TAIL when ones_cnt would reach STUFF_LEN, else go to IDLE with end_out<=1.
    - Otherwise go to SEND.
  - SEND, ones_cnt==STUFF_LEN: pause=1 and input is not consumed. s_out<=0, ones_cnt<=0, active_out<=1, start_out<=0, end_out<=0.
  - SEND, ones_cnt<STUFF_LEN: consume s_in, s_out<=s_in, and set ones_cnt<=s_in ? ones_cnt+1 : 0.
    - If end_in=1 and the new count equals STUFF_LEN, go to TAIL with end_out<=0.
    - If end_in=1 otherwise, set end_out<=1 and go to IDLE.
  - TAIL: emit stuff 0 with end_out<=1, active_out<=1, then go to IDLE. pause=0 in TAIL.
- start_in=1 while in SEND (protocol violation): abandon the current packet and treat it as a new packet exactly as from IDLE. start_out<=1, ones_cnt restarted, no end_out for the old packet.
- start_in in TAIL is ignored. Upstream guarantees a ≥1-cycle gap between packets.
- pause is never asserted in IDLE or TAIL.
- start_out and end_out are single-cycle pulses, always coincident with active_out=1.

Optional Feature:
- Macro: BS_STATS_EN.
- Defined: adds output stuff_cnt [7:0]. It is cleared to 0 on reset and on each accepted start_in, increments once per inserted stuff bit (SEND-stuff and TAIL), and saturates at 255.
- Undefined: the port and counter are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package usb_pkg:
  - typedef enum logic [1:0] bs_state_t {BS_IDLE, BS_SEND, BS_TAIL}.
  - localparam BS_STUFF_LEN_DEFAULT = 6.
- The TOKEN/packet-type encodings already in that package stay unchanged.
- Single module. The run-length counter is simple enough to stay inline, so there is no sub-module.

Test Plan:
- No stuffing: start_in with 8'b10101010 then end_in -> s_out 10101010 one cycle later, pause never 1, end_out with the 8th bit, 8 active cycles.
- Mid-packet stuff: input 1111111 0 (7 ones, then 0) -> output 111111 0 1 0. pause=1 exactly one cycle, after the 6th one; total 9 active cycles; end_out on the last 0.
- Twelve consecutive 1s: input 12×1 -> 111111 0 111111 0. The second stuff arrives via TAIL with end_out on it; 14 active cycles; pause asserted once (TAIL path).
- Stuff at end boundary: packet 00111111, end_in on the 6th one -> 00111111 0. end_out moves to the trailing 0; pause never asserted.
- Reset mid-packet: drop rst_n after 3 ones -> all outputs 0 immediately. A new packet after release starts with ones_cnt=0 (five 1s then 0 emit no stuff).
- BS_STATS_EN build: run the twelve-ones packet -> stuff_cnt=2. Issue a new start_in -> stuff_cnt=0.

Source files
------------

// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - shared USB transmit-path types and constants
//
// Purpose: common definitions for the USB transmit chain.
//   - PID_* : 4-bit packet identifier encodings (token/data/handshake).
//   - bs_state_t : bit stuffer FSM states.
//   - BS_STUFF_LEN_DEFAULT : run of 1s that forces a stuff 0.
package usb_pkg;

  // Token PIDs
  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SOF   = 4'b0101;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  // Data PIDs
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  // Handshake PIDs
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  typedef enum logic [1:0] {
    BS_IDLE,
    BS_SEND,
    BS_TAIL
  } bs_state_t;

  localparam int BS_STUFF_LEN_DEFAULT = 6;

endpackage

// File: rtl/bit_stuffer.sv
// rtl/bit_stuffer.sv - USB transmit bit stuffer between CRC stage and NRZI encoder
//
// Purpose: forwards the CRC stage's serial stream with a 0 inserted after
// every STUFF_LEN consecutive 1s, stalling upstream for each inserted bit.
// Optional feature macro: BS_STATS_EN (adds stuff_cnt).
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   s_in       in   serial bit from CRC stage
//   start_in   in   first bit of a packet
//   end_in     in   last bit of a packet
//   pause      out  holds upstream for one cycle while a stuff bit is emitted
//   s_out      out  stuffed serial bit (registered)
//   start_out  out  first output bit strobe (registered)
//   end_out    out  final output bit strobe, incl. trailing stuff (registered)
//   active_out out  s_out carries a packet bit (registered)
//   stuff_cnt  out  [7:0] saturating stuff bits in current packet (BS_STATS_EN only)
module bit_stuffer
  import usb_pkg::*;
#(
  parameter int STUFF_LEN = BS_STUFF_LEN_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_in,
  input  logic       start_in,
  input  logic       end_in,
  output logic       pause,
  output logic       s_out,
  output logic       start_out,
  output logic       end_out,
  output logic       active_out
`ifdef BS_STATS_EN
  ,
  output logic [7:0] stuff_cnt
`endif
);

  localparam int CW = $clog2(STUFF_LEN + 1);
  localparam logic [CW-1:0] STUFF_MAX = CW'(STUFF_LEN);

  bs_state_t     state_q, state_d;
  logic [CW-1:0] ones_q, ones_d;
  logic          s_out_q, s_out_d;
  logic          start_q, start_d;
  logic          end_q, end_d;
  logic          active_q, active_d;
  logic          accept_start;
  logic          stuff_now;

  // Depends only on registered state, so upstream never sees a
  // combinational loop through its own s_in/end_in.
  assign pause = (state_q == BS_SEND) && (ones_q == STUFF_MAX);

  always_comb begin
    state_d      = state_q;
    ones_d       = ones_q;
    s_out_d      = 1'b0;
    start_d      = 1'b0;
    end_d        = 1'b0;
    active_d     = 1'b0;
    accept_start = 1'b0;
    stuff_now    = 1'b0;

    // A start while sending abandons the old packet and restarts cleanly.
    if (start_in && (state_q != BS_TAIL)) begin
      accept_start = 1'b1;
      s_out_d      = s_in;
      start_d      = 1'b1;
      active_d     = 1'b1;
      ones_d       = s_in ? CW'(1) : '0;
      if (end_in) begin
        if (s_in && (STUFF_MAX == CW'(1))) begin
          state_d = BS_TAIL;
        end else begin
          end_d   = 1'b1;
          state_d = BS_IDLE;
        end
      end else begin
        state_d = BS_SEND;
      end
    end else begin
      case (state_q)
        BS_SEND: begin
          active_d = 1'b1;
          if (ones_q == STUFF_MAX) begin
            // Upstream is paused; emit the stuff 0 and leave s_in pending.
            stuff_now = 1'b1;
            s_out_d   = 1'b0;
            ones_d    = '0;
          end else begin
            s_out_d = s_in;
            ones_d  = s_in ? ones_q + CW'(1) : '0;
            if (end_in) begin
              if (s_in && (ones_q + CW'(1) == STUFF_MAX)) begin
                state_d = BS_TAIL;
              end else begin
                end_d   = 1'b1;
                state_d = BS_IDLE;
              end
            end
          end
        end
        BS_TAIL: begin
          stuff_now = 1'b1;
          s_out_d   = 1'b0;
          ones_d    = '0;
          end_d     = 1'b1;
          active_d  = 1'b1;
          state_d   = BS_IDLE;
        end
        default: begin
          state_d = BS_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= BS_IDLE;
      ones_q   <= '0;
      s_out_q  <= 1'b0;
      start_q  <= 1'b0;
      end_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ones_q   <= ones_d;
      s_out_q  <= s_out_d;
      start_q  <= start_d;
      end_q    <= end_d;
      active_q <= active_d;
    end
  end

  assign s_out      = s_out_q;
  assign start_out  = start_q;
  assign end_out    = end_q;
  assign active_out = active_q;

`ifdef BS_STATS_EN
  logic [7:0] stuff_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stuff_cnt_q <= 8'd0;
    end else if (accept_start) begin
      stuff_cnt_q <= 8'd0;
    end else if (stuff_now && (stuff_cnt_q != 8'hff)) begin
      stuff_cnt_q <= stuff_cnt_q + 8'd1;
    end
  end

  assign stuff_cnt = stuff_cnt_q;
`endif

endmodule

// File: tb/tb_bit_stuffer.sv
// tb/tb_bit_stuffer.sv - self-checking bench for bit_stuffer
module tb_bit_stuffer;

  localparam int SL = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s_in = 1'b0;
  logic start_in = 1'b0;
  logic end_in = 1'b0;
  logic pause, s_out, start_out, end_out, active_out;
`ifdef BS_STATS_EN
  logic [7:0] stuff_cnt;
`endif

  bit_stuffer #(.STUFF_LEN(SL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_in      (s_in),
    .start_in  (start_in),
    .end_in    (end_in),
    .pause     (pause),
    .s_out     (s_out),
    .start_out (start_out),
    .end_out   (end_out),
    .active_out(active_out)
`ifdef BS_STATS_EN
    ,
    .stuff_cnt (stuff_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic b;
    logic st;
    logic en;
  } obit_t;

  obit_t      exp_q[$];
  int         tests = 0;
  int         fails = 0;
  int         pause_cnt = 0;
  int         act_cnt = 0;
  logic [63:0] cap = '0;
  bit         chk_en = 1'b0;
  int         exp_pauses;
  int         exp_stuffs;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: walk the packet, append a 0 after every SL-long run of 1s.
  // Stuffs at the very end use the TAIL path and cost no upstream pause.
  function automatic void model(input logic bits[$]);
    int    run;
    obit_t t;
    run = 0;
    exp_pauses = 0;
    exp_stuffs = 0;
    for (int i = 0; i < bits.size(); i++) begin
      run = bits[i] ? run + 1 : 0;
      t = '{b: bits[i], st: (i == 0), en: 1'b0};
      exp_q.push_back(t);
      if (run == SL) begin
        t = '{b: 1'b0, st: 1'b0, en: 1'b0};
        exp_q.push_back(t);
        run = 0;
        exp_stuffs++;
        if (i < bits.size() - 1) exp_pauses++;
      end
    end
    t = exp_q.pop_back();
    t.en = 1'b1;
    exp_q.push_back(t);
  endfunction

  initial begin : compare
    obit_t e;
    forever begin
      @(negedge clk);
      if (rst_n && chk_en) begin
        if (pause) pause_cnt++;
        if (active_out) begin
          act_cnt++;
          cap = {cap[62:0], s_out};
          if (exp_q.size() == 0) begin
            chk("extra_bit", 64'(active_out), 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("out_bit", {61'd0, s_out, start_out, end_out}, {61'd0, e.b, e.st, e.en});
          end
        end else begin
          chk("idle_strobes", {62'd0, start_out, end_out}, 64'd0);
        end
      end
    end
  end

  task automatic send(input logic bits[$]);
    int idx;
    int guard;
    logic p;
    cap = '0;
    act_cnt = 0;
    pause_cnt = 0;
    model(bits);
    idx = 0;
    guard = 0;
    while (idx < bits.size() && guard < 500) begin
      @(negedge clk);
      s_in     = bits[idx];
      start_in = (idx == 0);
      end_in   = (idx == bits.size() - 1);
      p = pause;
      @(posedge clk);
      if (!p) idx++;
      guard++;
    end
    if (guard >= 500) chk("send_timeout", 64'(guard), 64'd0);
    @(negedge clk);
    s_in = 1'b0;
    start_in = 1'b0;
    end_in = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic bits_from(input logic [31:0] v, input int n, output logic q[$]);
    q = {};
    for (int i = n - 1; i >= 0; i--) q.push_back(v[i]);
  endtask

  initial begin : main
    logic q[$];
    int   n;

    #2;
    chk("rst_outs", {59'd0, pause, s_out, start_out, end_out, active_out}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk_en = 1'b1;

    bits_from(32'b10101010, 8, q);
    send(q);
    chk("nostuff_bits", cap, 64'b10101010);
    chk("nostuff_act", 64'(act_cnt), 64'd8);
    chk("nostuff_pause", 64'(pause_cnt), 64'd0);

    bits_from(32'b11111110, 8, q);
    send(q);
    chk("mid_bits", cap, 64'b111111010);
    chk("mid_act", 64'(act_cnt), 64'd9);
    chk("mid_pause", 64'(pause_cnt), 64'd1);

    bits_from(32'hfff, 12, q);
    send(q);
    chk("twelve_bits", cap, 64'b11111101111110);
    chk("twelve_act", 64'(act_cnt), 64'd14);
    chk("twelve_pause", 64'(pause_cnt), 64'd1);
`ifdef BS_STATS_EN
    chk("stats_twelve", 64'(stuff_cnt), 64'd2);
`endif

    bits_from(32'b00111111, 8, q);
    send(q);
    chk("endstuff_bits", cap, 64'b001111110);
    chk("endstuff_act", 64'(act_cnt), 64'd9);
    chk("endstuff_pause", 64'(pause_cnt), 64'd0);
`ifdef BS_STATS_EN
    chk("stats_restart", 64'(stuff_cnt), 64'd1);
`endif

    // Reset mid-packet after three 1s.
    #1 chk_en = 1'b0;
    @(negedge clk);
    s_in = 1'b1; start_in = 1'b1; end_in = 1'b0;
    @(negedge clk);
    start_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_active", 64'(active_out), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", {59'd0, pause, s_out, start_out, end_out, active_out}, 64'd0);
`ifdef BS_STATS_EN
    chk("mid_rst_stats", 64'(stuff_cnt), 64'd0);
`endif
    @(negedge clk);
    s_in = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk_en = 1'b1;
    bits_from(32'b111110, 6, q);
    send(q);
    chk("post_rst_bits", cap, 64'b111110);
    chk("post_rst_act", 64'(act_cnt), 64'd6);
    chk("post_rst_pause", 64'(pause_cnt), 64'd0);

    // Randomized packets, biased toward long runs of 1s.
    for (int k = 0; k < 60; k++) begin
      n = $urandom_range(1, 24);
      q = {};
      for (int i = 0; i < n; i++) begin
        if (k % 7 == 0) q.push_back(1'b1);
        else q.push_back($urandom_range(0, 3) != 0);
      end
      send(q);
      chk("rnd_pause", 64'(pause_cnt), 64'(exp_pauses));
      chk("rnd_act", 64'(act_cnt), 64'(n + exp_stuffs));
`ifdef BS_STATS_EN
      chk("rnd_stats", 64'(stuff_cnt), 64'(exp_stuffs));
`endif
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
